difference_m: RTL
=================

# difference_m

Inverse of the modulo-M accumulator (`summationM`). It samples the accumulator's registered outputs (`cnt`, `cop`, `con`) one sample per valid cycle and recovers the signed addend applied on each step. It also keeps a signed net-wrap count, so downstream logic can rebuild the full unwrapped sum. It sits directly after a `summationM` instance, for self-checking and for decoding a wrapped-phase stream back into increments.

## Interface
Parameters:
- `M`, 1000: modulus; must match the upstream accumulator; 2 ≤ M ≤ 2^(W-1)-1.
- `W`, 11: width of `cnt` and `addend` (signed).
- `CW`, 16: width of `wrap_cnt` (signed).

Ports:
- `clk`  in  1  rising-edge clock.
- `arst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  `cnt`/`cop`/`con` hold a new accumulator sample this cycle.
- `sync_clr`  in  1  synchronous restart; returns to IDLE; has priority over `in_valid`.
- `cnt`  in  W  signed accumulator value, legal range [-(M-1), M-1].
- `cop`  in  1  accumulator wrapped downward by M on this sample (positive overflow).
- `con`  in  1  accumulator wrapped upward by M on this sample (negative overflow).
- `addend`  out  W  signed recovered increment.
- `out_valid`  out  1  one-cycle strobe; `addend` is valid.
- `err`  out  1  one-cycle strobe, coincident with `out_valid` or a priming sample; protocol or range violation.
- `err_sticky`  out  1  set by any `err`; cleared by `arst` or `sync_clr`.
- `wrap_cnt`  out  CW  signed net count of `cop` minus `con` since priming; wraps two's-complement.

## Operation
- FSM states: IDLE (no reference sample) and RUN.
- **IDLE + in_valid:**
  - Store `cnt` as `prev`, clear `wrap_cnt`, go to RUN.
  - No `out_valid`. This is the priming sample; its `cop`/`con` are ignored.
- **RUN + in_valid:** compute in W+2 bits: `d = cnt - prev + (cop ? M : 0) - (con ? M : 0)`.
  - Normal case: `addend <= d[W-1:0]`, `out_valid <= 1`, `prev <= cnt`.
  - `wrap_cnt` increments on `cop` and decrements on `con`.
- **Error conditions**, checked in RUN on each valid sample:
  - `cop` and `con` both high.
  - `cnt` outside [-(M-1), M-1].
  - `d` outside [-2^(W-1), 2^(W-1)-1].
- **On error:**
  - `err <= 1`, `out_valid <= 1`, `addend <= 0`, `wrap_cnt` unchanged, `prev <= cnt`, state stays RUN.
  - In IDLE an out-of-range `cnt` asserts `err` (no `out_valid`) and the block stays IDLE.
- **sync_clr:** go to IDLE, clear `err_sticky` and `wrap_cnt`, no strobes that cycle, ignore the coincident sample.
- **in_valid low:** state, `prev`, `wrap_cnt` hold; strobes are 0; `addend` holds its last value.

## Timing
- All outputs are registered. Latency is 1 cycle from the `in_valid` edge to `out_valid`/`addend`/`err`/`wrap_cnt`.
- Throughput: one sample per cycle, back-to-back.
- There is no backpressure; the consumer must accept every `out_valid` strobe.
- Reset values: state IDLE, `prev` 0, `addend` 0, `out_valid` 0, `err` 0, `err_sticky` 0, `wrap_cnt` 0.
- `arst` mid-stream: the next valid sample after release is treated as priming.
- `wrap_cnt` rolls from 2^(CW-1)-1 to -2^(CW-1) without error.

## Structure
- Shared package holds:
  - the FSM state enum (IDLE, RUN);
  - a function `range_ok(value, M)` reused by `summationM` checks.
- One natural sub-module: `mod_diff`, combinational. It computes `d` plus the overflow and range flags, and is instanced once.
- The top-level file holds the FSM and registers.

## Test plan
All scenarios use M=1000, W=11.
1. **Priming:** after reset, sample `cnt=5`, then `cnt=12` → first sample gives no strobe; second gives `addend=7`, `out_valid=1`, latency 1.
2. **Positive wrap:** `prev=995`, sample `cnt=-998` with `cop=1` → `d = -998 - 995 + 1000 = -993`, so `addend=-993`. Check the same formula for `prev=995`, `cnt=3`, `cop=1` → `addend=8`; `wrap_cnt` +1 for each.
3. **Negative wrap:** `prev=-995`, sample `cnt=2` with `con=1` → `addend = 2 + 995 - 1000 = -3`; `wrap_cnt` -1.
4. **Cascade with summationM:** feed addend sequence 0..9, -9..9 repeating for 3000 cycles → `addend` output equals the input delayed by the chain latency; `err_sticky` stays 0.
5. **Protocol error:** `cop=1` and `con=1` together → `err=1`, `addend=0`, `err_sticky=1`. A following normal sample decodes correctly relative to the erroneous `cnt`.
6. **Reset mid-stream:**
   - `arst` asserted between samples → all outputs go to 0 immediately; the next sample primes.
   - `sync_clr` coincident with `in_valid` → sample ignored, state IDLE.

Source files
------------

// File: rtl/difference_m_pkg.sv
// Shared types and helpers for the modulo-M difference decoder.
// Holds the decoder FSM state encoding and a range check that the
// accumulator-side checks reuse.
package difference_m_pkg;

  // Decoder states: IDLE waits for a reference sample, RUN decodes.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // True when value lies in the legal accumulator range [-(m-1), m-1].
  function automatic logic range_ok(input int value, input int m);
    return (value >= -(m - 1)) && (value <= (m - 1));
  endfunction

endpackage

// File: rtl/difference_m_mod_diff.sv
// Combinational step recovery for the modulo-M difference decoder.
// Ports:
//   cnt      in  W   signed current accumulator sample
//   prev     in  W   signed previous (reference) sample
//   cop      in  1   sample wrapped downward by M
//   con      in  1   sample wrapped upward by M
//   diff_c   out W   low W bits of the recovered step
//   cnt_ok_c out 1   cnt lies in [-(M-1), M-1]
//   d_ok_c   out 1   full-width step fits in W signed bits
//   both_c   out 1   cop and con asserted together
module mod_diff
  import difference_m_pkg::*;
#(
  parameter int          M = 1000,
  parameter int unsigned W = 11
) (
  input  logic signed [W-1:0] cnt,
  input  logic signed [W-1:0] prev,
  input  logic                cop,
  input  logic                con,
  output logic signed [W-1:0] diff_c,
  output logic                cnt_ok_c,
  output logic                d_ok_c,
  output logic                both_c
);

  // Two guard bits cover cnt-prev (W+1 bits) plus or minus M.
  localparam int unsigned DW = W + 2;

  logic signed [DW-1:0] cnt_x;
  logic signed [DW-1:0] prev_x;
  logic signed [DW-1:0] m_x;
  logic signed [DW-1:0] up_x;
  logic signed [DW-1:0] dn_x;
  logic signed [DW-1:0] d_x;

  assign cnt_x  = DW'(cnt);
  assign prev_x = DW'(prev);
  assign m_x    = DW'(M);
  assign up_x   = cop ? m_x : DW'(0);
  assign dn_x   = con ? m_x : DW'(0);

  // Undo the wrap the accumulator applied on this step.
  assign d_x    = cnt_x - prev_x + up_x - dn_x;
  assign diff_c = d_x[W-1:0];

  // The step fits W signed bits when the guard bits match the W-1 sign bit.
  assign d_ok_c   = (d_x[DW-1:W-1] == '0) || (d_x[DW-1:W-1] == '1);
  assign cnt_ok_c = range_ok(int'(cnt), M);
  assign both_c   = cop && con;

endmodule

// File: rtl/difference_m.sv
// Inverse of a modulo-M accumulator: recovers each signed addend from
// consecutive accumulator samples and tracks the net wrap count.
// Ports:
//   clk        in  1   rising-edge clock
//   arst       in  1   asynchronous active-high reset
//   in_valid   in  1   cnt/cop/con carry a new sample
//   sync_clr   in  1   synchronous restart to IDLE, beats in_valid
//   cnt        in  W   signed accumulator value
//   cop        in  1   accumulator wrapped downward (positive overflow)
//   con        in  1   accumulator wrapped upward (negative overflow)
//   addend     out W   signed recovered increment
//   out_valid  out 1   addend strobe
//   err        out 1   protocol/range violation strobe
//   err_sticky out 1   latched err, cleared by arst or sync_clr
//   wrap_cnt   out CW  signed net count of cop minus con since priming
module difference_m
  import difference_m_pkg::*;
#(
  parameter int          M  = 1000,
  parameter int unsigned W  = 11,
  parameter int unsigned CW = 16
) (
  input  logic                 clk,
  input  logic                 arst,
  input  logic                 in_valid,
  input  logic                 sync_clr,
  input  logic signed [W-1:0]  cnt,
  input  logic                 cop,
  input  logic                 con,
  output logic signed [W-1:0]  addend,
  output logic                 out_valid,
  output logic                 err,
  output logic                 err_sticky,
  output logic signed [CW-1:0] wrap_cnt
);

  state_t              state_q;
  state_t              state_d;
  logic signed [W-1:0] prev_q;
  logic signed [W-1:0] prev_d;
  logic signed [W-1:0] addend_d;
  logic                out_valid_d;
  logic                err_d;
  logic                err_sticky_d;
  logic signed [CW-1:0] wrap_cnt_d;

  logic signed [W-1:0] diff_c;
  logic                cnt_ok_c;
  logic                d_ok_c;
  logic                both_c;

  // Step recovery relative to the stored reference sample.
  mod_diff #(
    .M (M),
    .W (W)
  ) u_mod_diff (
    .cnt      (cnt),
    .prev     (prev_q),
    .cop      (cop),
    .con      (con),
    .diff_c   (diff_c),
    .cnt_ok_c (cnt_ok_c),
    .d_ok_c   (d_ok_c),
    .both_c   (both_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    addend_d     = addend;
    out_valid_d  = 1'b0;
    err_d        = 1'b0;
    err_sticky_d = err_sticky;
    wrap_cnt_d   = wrap_cnt;

    if (sync_clr) begin
      state_d      = IDLE;
      err_sticky_d = 1'b0;
      wrap_cnt_d   = '0;
    end else if (in_valid) begin
      unique case (state_q)
        IDLE: begin
          // Priming sample: wrap flags carry no step information here.
          if (!cnt_ok_c) begin
            err_d        = 1'b1;
            err_sticky_d = 1'b1;
          end else begin
            prev_d     = cnt;
            wrap_cnt_d = '0;
            state_d    = RUN;
          end
        end
        RUN: begin
          out_valid_d = 1'b1;
          // Later samples decode relative to this one even when it is bad.
          prev_d      = cnt;
          if (both_c || !cnt_ok_c || !d_ok_c) begin
            err_d        = 1'b1;
            err_sticky_d = 1'b1;
            addend_d     = '0;
          end else begin
            addend_d = diff_c;
            if (cop) begin
              wrap_cnt_d = wrap_cnt + CW'(1);
            end else if (con) begin
              wrap_cnt_d = wrap_cnt - CW'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q    <= IDLE;
      prev_q     <= '0;
      addend     <= '0;
      out_valid  <= 1'b0;
      err        <= 1'b0;
      err_sticky <= 1'b0;
      wrap_cnt   <= '0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      addend     <= addend_d;
      out_valid  <= out_valid_d;
      err        <= err_d;
      err_sticky <= err_sticky_d;
      wrap_cnt   <= wrap_cnt_d;
    end
  end

endmodule
